// File: rtl/mem_if_pkg.sv
// Shared types and widths for the 128-bit cache-to-memory line interface.
// Used by the cache controllers and by the memory-side responder.
`default_nettype none

package mem_if_pkg;

  localparam int LINE_W  = 128;
  localparam int MADDR_W = 28;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/line_ram.sv
// Single-port DEPTH x LINE_W line array; read data is registered and held
// until the next read, and is the only part of this block that is reset.
`default_nettype none

module line_ram
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/line_mem_responder.sv
// Memory-side responder for the line interface: one request at a time, fixed
// programmable latency, one-cycle ready pulse, sticky errors, saturating stats.
`default_nettype none

module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [MADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]  mem_wdata,
  output logic [LINE_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic               err_both,
  output logic               err_change,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt
);

  localparam int       IDX_W      = $clog2(DEPTH);
  localparam logic [7:0] c_LAT_INIT = 8'(LATENCY - 1);

  mem_state_t         r_state;
  logic [7:0]         r_lat;
  logic               r_rd_req;
  logic               r_wr_req;
  logic [MADDR_W-1:0] r_addr;
  logic [LINE_W-1:0]  r_wdata;
  logic               r_ready;
  logic               r_err_both;
  logic               r_err_change;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_wr_cnt;

  logic w_done;
  logic w_commit_wr;
  logic w_commit_rd;
  logic w_mismatch;

  // Completion is gated by rst so a reset on the final BUSY edge still aborts.
  assign w_done      = (r_state == ST_BUSY) && (r_lat == 8'd0) && !rst;
  assign w_commit_wr = w_done && r_wr_req;
  assign w_commit_rd = w_done && !r_wr_req;
  assign w_mismatch  = (mem_read != r_rd_req) || (mem_write != r_wr_req) ||
                       (mem_addr != r_addr) || (mem_wdata != r_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lat        <= 8'd0;
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b0;
      r_err_both   <= 1'b0;
      r_err_change <= 1'b0;
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (mem_read || mem_write) begin
            r_rd_req <= mem_read;
            r_wr_req <= mem_write;
            r_addr   <= mem_addr;
            r_wdata  <= mem_wdata;
            r_lat    <= c_LAT_INIT;
            r_state  <= ST_BUSY;
            if (mem_read && mem_write) begin
              r_err_both <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (w_mismatch) begin
            r_err_change <= 1'b1;
          end
          if (r_lat == 8'd0) begin
            r_ready <= 1'b1;
            r_state <= ST_GAP;
            if (r_wr_req) begin
              if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
            end else begin
              if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        ST_GAP: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  line_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_line_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit_wr),
    .i_re    (w_commit_rd),
    .i_idx   (r_addr[IDX_W-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (mem_rdata)
  );

  assign mem_ready  = r_ready;
  assign err_both   = r_err_both;
  assign err_change = r_err_change;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: transaction table plus corner sequences.
`default_nettype none

module tb_line_mem_responder;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         err_both;
  logic         err_change;
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D1 = 128'hDEADBEEF_CAFEF00D_89ABCDEF_01234567;
  localparam logic [127:0] D2 = 128'h55555555_00000005_AAAAAAAA_00000005;
  localparam logic [127:0] D3 = 128'hFFFF0000_FFFF0000_0000FFFF_000000FF;
  localparam logic [127:0] D5 = 128'h0BADF00D_0BADF00D_12345678_00000030;
  localparam logic [127:0] D6 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] D7 = 128'h77777777_77777777_77777777_77777777;
  localparam logic [127:0] D8 = 128'h40404040_13579BDF_2468ACE0_00000040;

  line_mem_responder #(
    .LATENCY (4),
    .DEPTH   (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .err_both   (err_both),
    .err_change (err_change),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    int           exp_rd;
    int           exp_wr;
    logic         exp_both;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives a request at #1 after an edge (state IDLE), returns edges from
  // acceptance to the observed ready pulse, or -1 if it never came.
  task automatic run_txn(input logic rd, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wdata, output int lat);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = n - 1;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int lat;
    int gap;
    bit seen;

    vecs[0] = '{1'b0, 1'b1, 28'h0000010, D1,     128'd0, 0, 1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 28'h0000010, 128'd0, D1,     1, 1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 28'h0000005, D2,     D1,     1, 2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 28'h0000105, 128'd0, D2,     2, 2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 28'h00000FF, D3,     D2,     2, 3, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 28'h00001FF, 128'd0, D3,     3, 3, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 28'h0000003, D6,     D3,     3, 4, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 28'h0000030, D5,     D3,     3, 5, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 28'h0000030, 128'd0, D5,     4, 5, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 28'h0000003, 128'd0, D6,     5, 5, 1'b1};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    // Request held alongside reset must not be accepted.
    mem_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_write = 1'b0;
    chk("reset_rdata",  mem_rdata, 128'd0);
    chk("reset_ready",  {127'd0, mem_ready}, 128'd0);
    chk("reset_errs",   {126'd0, err_both, err_change}, 128'd0);
    chk("reset_counts", {96'd0, rd_cnt, wr_cnt}, 128'd0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'd4);
      chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_width", i), {127'd0, mem_ready}, 128'd0);
      chk($sformatf("v%0d_rdata_held", i), mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_rd_cnt", i), 128'(rd_cnt), 128'(vecs[i].exp_rd));
      chk($sformatf("v%0d_wr_cnt", i), 128'(wr_cnt), 128'(vecs[i].exp_wr));
      chk($sformatf("v%0d_err_both", i), {127'd0, err_both}, {127'd0, vecs[i].exp_both});
      chk($sformatf("v%0d_err_change", i), {127'd0, err_change}, 128'd0);
    end

    // Address changes mid-BUSY: flag sets, original line is returned.
    mem_read = 1'b1; mem_addr = 28'h0000010; mem_wdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_addr = 28'h00000FF;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin lat = n; break; end
    end
    mem_read = 1'b0;
    chk("chg_ready_seen", 128'(lat), 128'd3);
    chk("chg_rdata", mem_rdata, D1);
    chk("chg_err_change", {127'd0, err_change}, 128'd1);
    @(posedge clk); #1;

    // Reset two cycles into a write of line 3 aborts it.
    mem_write = 1'b1; mem_addr = 28'h0000003; mem_wdata = D7;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; mem_write = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
      if (n == 1) rst = 1'b0;
    end
    chk("abort_no_ready", {127'd0, seen}, 128'd0);
    chk("abort_counts", {96'd0, rd_cnt, wr_cnt}, 128'd0);
    chk("abort_errs", {126'd0, err_both, err_change}, 128'd0);
    chk("abort_rdata", mem_rdata, 128'd0);
    run_txn(1'b1, 1'b0, 28'h0000003, 128'd0, lat);
    chk("abort_read_lat", 128'(lat), 128'd4);
    chk("abort_read_old", mem_rdata, D6);
    @(posedge clk); #1;
    chk("abort_rd_cnt", 128'(rd_cnt), 128'd1);

    // Back-to-back write then read: request switched during GAP.
    mem_write = 1'b1; mem_addr = 28'h0000040; mem_wdata = D8;
    seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin seen = 1'b1; break; end
    end
    chk("b2b_write_done", {127'd0, seen}, 128'd1);
    mem_write = 1'b0; mem_read = 1'b1;
    gap = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin gap = n; break; end
    end
    mem_read = 1'b0;
    chk("b2b_spacing", 128'(gap), 128'd6);
    chk("b2b_rdata", mem_rdata, D8);
    chk("b2b_counts", {96'd0, rd_cnt, wr_cnt}, {96'd0, 16'd2, 16'd1});
    chk("b2b_err_change", {127'd0, err_change}, 128'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
